// File: rtl/conv_output_collector_if.sv
// Result stream between the convolution datapath, the output collector and the host.
// The producer side carries a single-cycle pulse; the host side is valid/ready.
interface conv_output_collector_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic [31:0]           in_x;
  logic [31:0]           in_y;
  logic [31:0]           in_ch;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [31:0]           out_x;
  logic [31:0]           out_y;
  logic [31:0]           out_ch;

  // Environment side: produces results and consumes the FIFO head.
  modport master (
    output in_valid, in_data, in_x, in_y, in_ch, out_ready,
    input  out_valid, out_data, out_x, out_y, out_ch
  );

  // Collector side.
  modport slave (
    input  in_valid, in_data, in_x, in_y, in_ch, out_ready,
    output out_valid, out_data, out_x, out_y, out_ch
  );
endinterface

// File: rtl/conv_output_collector.sv
// Buffers convolution results in a small FWFT FIFO, hands them to the host over valid/ready,
// flags dropped results and pulses done once every expected output has been delivered.
module conv_output_collector #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned FIFO_DEPTH         = 8,
  parameter int unsigned LOG2_FIFO_DEPTH    = 3,
  parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
  parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
  parameter int unsigned OUTPUT_NB_CHANNELS = 64
) (
  input  logic                       clk,
  input  logic                       arst_n_in,
  input  logic                       start,
  conv_output_collector_if.slave     bus,
  output logic [LOG2_FIFO_DEPTH:0]   fifo_count,
  output logic                       overflow,
  output logic                       collecting,
  output logic                       done
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int unsigned TOTAL_INT =
      FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
  localparam logic [31:0] TOTAL    = TOTAL_INT[31:0];
  localparam logic [31:0] LAST_IDX = TOTAL - 32'd1;

  typedef logic [LOG2_FIFO_DEPTH-1:0] ptr_t;
  typedef logic [LOG2_FIFO_DEPTH:0]   cnt_t;

  logic [1:0]  state_q, state_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  cnt_t        count_q, count_d;
  logic [31:0] received_q, received_d;
  logic        overflow_q, overflow_d;

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [31:0]           mem_x    [FIFO_DEPTH];
  logic [31:0]           mem_y    [FIFO_DEPTH];
  logic [31:0]           mem_ch   [FIFO_DEPTH];

  logic active;
  logic full;
  logic pop;
  logic push;

  assign active = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
  // Depth is a power of two, so the count MSB alone marks a full FIFO.
  assign full   = count_q[LOG2_FIFO_DEPTH];

  assign bus.out_valid = active && (count_q != '0);
  assign pop           = bus.out_valid && bus.out_ready;
  assign push          = (state_q == ST_COLLECT) && bus.in_valid && (!full || pop);

  // Head is read straight from storage; zeroed whenever nothing valid is presented.
  always_comb begin
    bus.out_data = '0;
    bus.out_x    = '0;
    bus.out_y    = '0;
    bus.out_ch   = '0;
    if (bus.out_valid) begin
      bus.out_data = mem_data[rd_ptr_q];
      bus.out_x    = mem_x[rd_ptr_q];
      bus.out_y    = mem_y[rd_ptr_q];
      bus.out_ch   = mem_ch[rd_ptr_q];
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    received_d = received_q;
    overflow_d = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_COLLECT;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          received_d = '0;
          overflow_d = 1'b0;
        end
      end
      ST_COLLECT: begin
        if (bus.in_valid) begin
          // Dropped results still count so the run can complete.
          received_d = received_q + 32'd1;
          if (!push) overflow_d = 1'b1;
          if (received_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.in_valid) overflow_d = 1'b1;
        if (count_d == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      received_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      received_q <= received_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= bus.in_data;
      mem_x[wr_ptr_q]    <= bus.in_x;
      mem_y[wr_ptr_q]    <= bus.in_y;
      mem_ch[wr_ptr_q]   <= bus.in_ch;
    end
  end

  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign collecting = active;
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_output_collector.sv
// Directed and randomized bench for conv_output_collector with a queue-based reference model.
module tb_conv_output_collector;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LOG2  = 2;
  localparam int TOTAL = 8;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ch;
  } ent_t;

  logic            clk = 1'b0;
  logic            arst_n_in;
  logic            start;
  logic [LOG2:0]   fifo_count;
  logic            overflow;
  logic            collecting;
  logic            done;

  conv_output_collector_if #(.DATA_WIDTH(DW)) bus ();

  conv_output_collector #(
    .DATA_WIDTH        (DW),
    .FIFO_DEPTH        (DEPTH),
    .LOG2_FIFO_DEPTH   (LOG2),
    .FEATURE_MAP_WIDTH (2),
    .FEATURE_MAP_HEIGHT(2),
    .OUTPUT_NB_CHANNELS(2)
  ) dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .start     (start),
    .bus       (bus),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .collecting(collecting),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 collect, 2 drain, 3 done.
  int   phase;
  ent_t q[$];
  bit   m_ovf;
  int   m_recv;
  int   checks;
  int   failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit mvalid;
    mvalid = (phase == 1 || phase == 2) && q.size() != 0;
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, mvalid});
    if (mvalid) begin
      check("out_data", bus.out_data, q[0].d);
      check("out_x", bus.out_x, q[0].x);
      check("out_y", bus.out_y, q[0].y);
      check("out_ch", bus.out_ch, q[0].ch);
    end
    check("fifo_count", {29'd0, fifo_count}, q.size());
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("collecting", {31'd0, collecting}, (phase == 1 || phase == 2) ? 1 : 0);
    check("done", {31'd0, done}, (phase == 3) ? 1 : 0);
  endtask

  task automatic model_step(input bit st, input bit iv, input ent_t e, input bit rdy);
    bit pop;
    pop = (phase == 1 || phase == 2) && q.size() != 0 && rdy;
    if (pop) void'(q.pop_front());
    case (phase)
      0: if (st) begin
        q.delete();
        m_recv = 0;
        m_ovf  = 1'b0;
        phase  = 1;
      end
      1: if (iv) begin
        if (q.size() < DEPTH) q.push_back(e);
        else m_ovf = 1'b1;
        m_recv++;
        if (m_recv == TOTAL) phase = 2;
      end
      2: begin
        if (iv) m_ovf = 1'b1;
        if (q.size() == 0) phase = 3;
      end
      default: phase = 0;
    endcase
  endtask

  // One clock: drive at negedge, check 1ns later, then advance the model for the posedge.
  task automatic cycle(input bit st, input bit iv, input logic [31:0] d, input bit rdy);
    ent_t e;
    @(negedge clk);
    e.d  = d;
    e.x  = $urandom;
    e.y  = $urandom;
    e.ch = $urandom;
    start         = st;
    bus.in_valid  = iv;
    bus.in_data   = e.d;
    bus.in_x      = e.x;
    bus.in_y      = e.y;
    bus.in_ch     = e.ch;
    bus.out_ready = rdy;
    #1;
    check_outputs();
    model_step(st, iv, e, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n_in     = 1'b0;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    phase  = 0;
    q.delete();
    m_ovf  = 1'b0;
    m_recv = 0;
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_x", bus.out_x, 0);
    check("rst_out_y", bus.out_y, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_fifo_count", {29'd0, fifo_count}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_collecting", {31'd0, collecting}, 0);
    check("rst_done", {31'd0, done}, 0);
    @(negedge clk);
    arst_n_in = 1'b1;
  endtask

  task automatic finish_run();
    for (int i = 0; i < 20 && phase != 0; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("idle_after_run", {31'd0, collecting}, 0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    phase         = 0;
    m_ovf         = 1'b0;
    m_recv        = 0;
    arst_n_in     = 1'b0;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_ch     = '0;
    bus.out_ready = 1'b0;
    do_reset();

    // Streaming run with host always ready.
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, i, 1'b1);
    finish_run();

    // Host stalled: fifth result dropped, overflow sticks through completion.
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, i, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 6; i <= 8; i++) cycle(1'b0, 1'b1, i, 1'b1);
    finish_run();

    // Full FIFO with simultaneous push and pop across pointer wrap.
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, i, 1'b0);
    for (int i = 5; i <= 8; i++) cycle(1'b0, 1'b1, i, 1'b1);
    finish_run();

    // in_valid in IDLE is ignored; in_valid in DRAIN sets overflow.
    cycle(1'b0, 1'b1, $urandom, 1'b1);
    cycle(1'b0, 1'b1, $urandom, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    for (int i = 1; i <= 6; i++) cycle(1'b0, 1'b1, i, 1'b1);
    for (int i = 7; i <= 8; i++) cycle(1'b0, 1'b1, i, 1'b0);
    cycle(1'b0, 1'b1, 32'd99, 1'b0);
    cycle(1'b0, 1'b1, 32'd100, 1'b0);
    finish_run();

    // Three-cycle host stall with a valid head.
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    for (int i = 1; i <= 2; i++) cycle(1'b0, 1'b1, $urandom, 1'b1);
    cycle(1'b0, 1'b1, $urandom, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 4; i <= 8; i++) cycle(1'b0, 1'b1, $urandom, 1'b1);
    finish_run();

    // Reset mid-run, then a clean run.
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b1, i, 1'b0);
    do_reset();
    repeat (2) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, $urandom, 1'b1);
    finish_run();

    // Randomized runs.
    for (int r = 0; r < 4; r++) begin
      cycle(1'b1, 1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 300 && phase != 0; i++)
        cycle(1'b0, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0));
      finish_run();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
